// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared types, default raster timing and test-pattern colours for the VGA scanout
// Contents:
//   rgb_t        4:4:4 colour, {r,g,b}
//   *_DEF        default 640x480 timing (pixels / lines) and derived totals and sync windows
//   bar_color()  colour of one of the eight vertical test bars, left to right
package vga_pkg;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb_t;

    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FP_DEF     = 16;
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BP_DEF     = 48;
    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FP_DEF     = 10;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BP_DEF     = 33;

    localparam int H_TOTAL_DEF      = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
    localparam int V_TOTAL_DEF      = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;
    localparam int H_SYNC_START_DEF = H_ACTIVE_DEF + H_FP_DEF;
    localparam int H_SYNC_END_DEF   = H_SYNC_START_DEF + H_SYNC_DEF;
    localparam int V_SYNC_START_DEF = V_ACTIVE_DEF + V_FP_DEF;
    localparam int V_SYNC_END_DEF   = V_SYNC_START_DEF + V_SYNC_DEF;

    function automatic rgb_t bar_color(input logic [2:0] idx);
        case (idx)
            3'd0:    return rgb_t'(12'hFFF);
            3'd1:    return rgb_t'(12'hFF0);
            3'd2:    return rgb_t'(12'h0FF);
            3'd3:    return rgb_t'(12'h0F0);
            3'd4:    return rgb_t'(12'hF0F);
            3'd5:    return rgb_t'(12'hF00);
            3'd6:    return rgb_t'(12'h00F);
            default: return rgb_t'(12'h000);
        endcase
    endfunction

endpackage

// File: rtl/vga_scanout_if.sv
// rtl/vga_scanout_if.sv - scan-coordinate / pixel-return link between the scanout and the sprite cluster
// Signals:
//   x, y   current scan coordinates (driven by the scanout, modport master)
//   pixel  colour returned for x/y, {r,g,b} (driven by the sprite cluster, modport slave)
interface vga_scanout_if #(
    parameter int INT_WIDTH   = 16,
    parameter int COLOR_WIDTH = 12
) ();
    logic [INT_WIDTH-1:0]   x;
    logic [INT_WIDTH-1:0]   y;
    logic [COLOR_WIDTH-1:0] pixel;

    modport master (output x, output y, input pixel);
    modport slave  (input x, input y, output pixel);
endinterface

// File: rtl/vga_timing.sv
// rtl/vga_timing.sv - pixel-clock divider, h/v raster counters and sync/active decode
// Ports:
//   clk, rst      system clock, synchronous active-high reset
//   tick          one clk per pixel period (div == CLK_DIV-1); raster state moves on it
//   capture       clk on which the returned pixel for the current h/v is valid
//   h, v          raster counters
//   active        h/v inside the visible area
//   hs_on, vs_on  h/v inside the sync window (polarity applied by the caller)
//   vblank_next   blanking state of the line that v will hold after this tick
//   wrap          tick on which h and v both return to 0
module vga_timing #(
    parameter int H_ACTIVE      = 640,
    parameter int H_FP          = 16,
    parameter int H_SYNC        = 96,
    parameter int H_BP          = 48,
    parameter int V_ACTIVE      = 480,
    parameter int V_FP          = 10,
    parameter int V_SYNC        = 2,
    parameter int V_BP          = 33,
    parameter int CLK_DIV       = 4,
    parameter int PIXEL_LATENCY = 1,
    parameter int INT_WIDTH     = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    output logic                 tick,
    output logic                 capture,
    output logic [INT_WIDTH-1:0] h,
    output logic [INT_WIDTH-1:0] v,
    output logic                 active,
    output logic                 hs_on,
    output logic                 vs_on,
    output logic                 vblank_next,
    output logic                 wrap
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int H_SS    = H_ACTIVE + H_FP;
    localparam int H_SE    = H_SS + H_SYNC;
    localparam int V_SS    = V_ACTIVE + V_FP;
    localparam int V_SE    = V_SS + V_SYNC;
    localparam int DIV_W   = $clog2(CLK_DIV);

    logic [DIV_W-1:0]     div;
    logic                 h_last;
    logic                 v_last;
    logic [INT_WIDTH-1:0] v_after;

    assign tick    = (div == DIV_W'(CLK_DIV - 1));
    assign capture = (div == DIV_W'(PIXEL_LATENCY - 1));
    assign h_last  = (h == INT_WIDTH'(H_TOTAL - 1));
    assign v_last  = (v == INT_WIDTH'(V_TOTAL - 1));
    assign wrap    = tick && h_last && v_last;

    assign active = (h < INT_WIDTH'(H_ACTIVE)) && (v < INT_WIDTH'(V_ACTIVE));
    assign hs_on  = (h >= INT_WIDTH'(H_SS)) && (h < INT_WIDTH'(H_SE));
    assign vs_on  = (v >= INT_WIDTH'(V_SS)) && (v < INT_WIDTH'(V_SE));

    // Line number v will hold once this tick has been applied, so vblank
    // can be registered in step with y.
    assign v_after     = !h_last ? v : (v_last ? '0 : v + INT_WIDTH'(1));
    assign vblank_next = (v_after >= INT_WIDTH'(V_ACTIVE));

    always_ff @(posedge clk) begin
        if (rst) begin
            div <= '0;
            h   <= '0;
            v   <= '0;
        end else begin
            div <= tick ? '0 : div + DIV_W'(1);
            if (tick) begin
                if (h_last) begin
                    h <= '0;
                    v <= v_last ? '0 : v + INT_WIDTH'(1);
                end else begin
                    h <= h + INT_WIDTH'(1);
                end
            end
        end
    end
endmodule

// File: rtl/vga_scanout.sv
// rtl/vga_scanout.sv - VGA raster generator and registered pixel/sync output stage
// Ports:
//   clk, rst             system clock, synchronous active-high reset
//   scan                 vga_scanout_if.master: x/y out to the sprite cluster, pixel back
//   test_en              selects the colour-bar test pattern (only with VGA_TEST_PATTERN_EN)
//   vga_r/g/b, hs, vs    registered VGA pins, one pixel period behind x/y
//   vblank               high while y >= V_ACTIVE
//   frame_start          one-clk pulse when the raster wraps to 0,0
//   frame_count          completed frames, wrapping
// Build option: define VGA_TEST_PATTERN_EN to include the eight-bar test pattern.
module vga_scanout
    import vga_pkg::*;
#(
    parameter int H_ACTIVE      = H_ACTIVE_DEF,
    parameter int H_FP          = H_FP_DEF,
    parameter int H_SYNC        = H_SYNC_DEF,
    parameter int H_BP          = H_BP_DEF,
    parameter int V_ACTIVE      = V_ACTIVE_DEF,
    parameter int V_FP          = V_FP_DEF,
    parameter int V_SYNC        = V_SYNC_DEF,
    parameter int V_BP          = V_BP_DEF,
    parameter int CLK_DIV       = 4,
    parameter int PIXEL_LATENCY = 1,
    parameter int INT_WIDTH     = 16,
    parameter bit SYNC_POL      = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    vga_scanout_if.master        scan,
    input  logic                 test_en,
    output logic [3:0]           vga_r,
    output logic [3:0]           vga_g,
    output logic [3:0]           vga_b,
    output logic                 vga_hs,
    output logic                 vga_vs,
    output logic                 vblank,
    output logic                 frame_start,
    output logic [INT_WIDTH-1:0] frame_count
);
    logic                 tick;
    logic                 capture;
    logic [INT_WIDTH-1:0] h;
    logic [INT_WIDTH-1:0] v;
    logic                 active;
    logic                 hs_on;
    logic                 vs_on;
    logic                 vblank_next;
    logic                 wrap;
    rgb_t                 src_pixel;
    rgb_t                 cap;

    vga_timing #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .CLK_DIV(CLK_DIV), .PIXEL_LATENCY(PIXEL_LATENCY), .INT_WIDTH(INT_WIDTH)
    ) u_timing (
        .clk(clk), .rst(rst), .tick(tick), .capture(capture), .h(h), .v(v),
        .active(active), .hs_on(hs_on), .vs_on(vs_on),
        .vblank_next(vblank_next), .wrap(wrap)
    );

    // h/v are already registers that move only on tick, so x/y track them directly.
    assign scan.x = h;
    assign scan.y = v;

`ifdef VGA_TEST_PATTERN_EN
    logic [INT_WIDTH-1:0] bar_q;
    logic [2:0]           bar_idx;

    // Beyond the visible width the bar index is clamped; those pixels are blanked anyway.
    assign bar_q     = h / INT_WIDTH'(H_ACTIVE / 8);
    assign bar_idx   = (bar_q > INT_WIDTH'(7)) ? 3'd7 : bar_q[2:0];
    assign src_pixel = test_en ? bar_color(bar_idx) : rgb_t'(scan.pixel);
`else
    logic unused_test_en;
    assign unused_test_en = test_en;
    assign src_pixel      = rgb_t'(scan.pixel);
`endif

    // Capture lands mid-period; the following tick then registers colour and
    // syncs from the same h/v, giving one pixel period of delay for all pins.
    always_ff @(posedge clk) begin
        if (rst) begin
            cap         <= '0;
            vga_r       <= '0;
            vga_g       <= '0;
            vga_b       <= '0;
            vga_hs      <= ~SYNC_POL;
            vga_vs      <= ~SYNC_POL;
            vblank      <= 1'b0;
            frame_start <= 1'b0;
            frame_count <= '0;
        end else begin
            if (capture) begin
                cap <= src_pixel;
            end
            if (tick) begin
                vga_r  <= active ? cap.r : 4'h0;
                vga_g  <= active ? cap.g : 4'h0;
                vga_b  <= active ? cap.b : 4'h0;
                vga_hs <= hs_on ? SYNC_POL : ~SYNC_POL;
                vga_vs <= vs_on ? SYNC_POL : ~SYNC_POL;
                vblank <= vblank_next;
            end
            frame_start <= wrap;
            if (wrap) begin
                frame_count <= frame_count + INT_WIDTH'(1);
            end
        end
    end
endmodule

// File: tb/tb_vga_scanout.sv
// tb/tb_vga_scanout.sv - self-checking bench for vga_scanout on a reduced 16x8 raster
module tb_vga_scanout;
    localparam int HA = 16, HF = 2, HS = 3, HB = 3;
    localparam int VA = 8,  VF = 1, VS = 2, VB = 1;
    localparam int DIV = 4;
    localparam int HT = HA + HF + HS + HB;     // 24
    localparam int VT = VA + VF + VS + VB;     // 12
    localparam int FRAME = HT * VT * DIV;      // 1152 clks

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        test_en = 1'b0;
    logic [3:0]  vga_r, vga_g, vga_b;
    logic        vga_hs, vga_vs, vblank, frame_start;
    logic [15:0] frame_count;

    int errors = 0;
    int checks = 0;

    vga_scanout_if #(.INT_WIDTH(16), .COLOR_WIDTH(12)) scan ();

    vga_scanout #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .CLK_DIV(DIV), .PIXEL_LATENCY(1), .INT_WIDTH(16), .SYNC_POL(1'b0)
    ) dut (
        .clk(clk), .rst(rst), .scan(scan), .test_en(test_en),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
        .vga_hs(vga_hs), .vga_vs(vga_vs), .vblank(vblank),
        .frame_start(frame_start), .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] model(input logic [15:0] xx, input logic [15:0] yy);
        return {xx[3:0], yy[3:0], 4'hA};
    endfunction

    function automatic logic [11:0] bar_exp(input int xx);
        logic [11:0] tbl [8];
        tbl = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0, 12'hF0F, 12'hF00, 12'h00F, 12'h000};
        return tbl[xx / (HA / 8)];
    endfunction

    // Expected {rgb, hs, vs} for one pixel period at (xx, yy).
    function automatic logic [13:0] exp_pins(input int xx, input int yy, input logic te);
        logic [11:0] rgb;
        logic        hs, vs, use_bars;
`ifdef VGA_TEST_PATTERN_EN
        use_bars = te;
`else
        use_bars = 1'b0;
`endif
        rgb = 12'h000;
        if (xx < HA && yy < VA) rgb = use_bars ? bar_exp(xx) : model(16'(xx), 16'(yy));
        hs = (xx >= HA + HF && xx < HA + HF + HS) ? 1'b0 : 1'b1;
        vs = (yy >= VA + VF && yy < VA + VF + VS) ? 1'b0 : 1'b1;
        return {rgb, hs, vs};
    endfunction

    // Sprite-cluster model: valid colour only on the first negedge after x/y
    // change (the cycle the DUT samples); random junk the rest of the period.
    logic [15:0] last_x = '0;
    int          ph = 0;
    always @(negedge clk) begin
        if (rst || scan.x !== last_x) ph = 0;
        else ph = ph + 1;
        last_x = scan.x;
        scan.pixel = (ph == 0) ? model(scan.x, scan.y) : 12'($urandom);
    end

    logic [13:0] sb [$];

    task automatic do_reset;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_reset;
        do_reset();
        checks++;
        if ({scan.x, scan.y} !== 32'h0) begin
            errors++; $display("FAIL reset_xy got x=%0d y=%0d want 0 0", scan.x, scan.y);
        end
        checks++;
        if ({vga_r, vga_g, vga_b, vga_hs, vga_vs, vblank, frame_start} !== {12'h000, 1'b1, 1'b1, 1'b0, 1'b0}) begin
            errors++; $display("FAIL reset_pins got rgb=%h hs=%b vs=%b vb=%b fs=%b", {vga_r, vga_g, vga_b}, vga_hs, vga_vs, vblank, frame_start);
        end
        checks++;
        if (frame_count !== 16'd0) begin
            errors++; $display("FAIL reset_frame_count got %0d want 0", frame_count);
        end
        for (int i = 1; i <= 4; i++) begin
            @(posedge clk); #1;
            checks++;
            if (scan.x !== ((i == 4) ? 16'd1 : 16'd0)) begin
                errors++; $display("FAIL reset_first_tick clk%0d got x=%0d want %0d", i, scan.x, (i == 4) ? 1 : 0);
            end
        end
    endtask

    task automatic test_hsync;
        logic prev;
        bit   found;
        int   n, p;
        do_reset();
        prev = vga_hs; found = 0;
        for (int i = 0; i < 400 && !found; i++) begin
            @(posedge clk); #1;
            if (prev === 1'b1 && vga_hs === 1'b0) found = 1;
            prev = vga_hs;
        end
        checks++;
        if (!found) begin
            errors++; $display("FAIL hs_fall got none want fall within 400 clks");
        end else begin
            checks++;
            if (scan.x !== 16'(HA + HF + 1)) begin
                errors++; $display("FAIL hs_fall_x got %0d want %0d", scan.x, HA + HF + 1);
            end
            n = 0;
            do begin @(posedge clk); #1; n++; end while (vga_hs === 1'b0 && n < 200);
            checks++;
            if (n !== HS * DIV) begin
                errors++; $display("FAIL hs_width got %0d want %0d", n, HS * DIV);
            end
            p = n;
            do begin @(posedge clk); #1; p++; end while (vga_hs === 1'b1 && p < 400);
            checks++;
            if (p !== HT * DIV) begin
                errors++; $display("FAIL hs_period got %0d want %0d", p, HT * DIV);
            end
        end
    endtask

    task automatic test_frame;
        int cyc, pulses, p1, p2, vs_low;
        do_reset();
        cyc = 0; pulses = 0; p1 = 0; p2 = 0; vs_low = 0;
        while (pulses < 2 && cyc < 3 * FRAME + 20) begin
            @(posedge clk); #1; cyc++;
            checks++;
            if (vblank !== (scan.y >= 16'(VA))) begin
                errors++; $display("FAIL vblank y=%0d got %b want %b", scan.y, vblank, scan.y >= 16'(VA));
            end
            if (pulses == 1 && vga_vs === 1'b0) vs_low++;
            if (frame_start === 1'b1) begin
                pulses++;
                if (pulses == 1) p1 = cyc; else p2 = cyc;
                checks++;
                if (frame_count !== 16'(pulses)) begin
                    errors++; $display("FAIL frame_count got %0d want %0d", frame_count, pulses);
                end
                checks++;
                if ({scan.x, scan.y} !== 32'h0) begin
                    errors++; $display("FAIL frame_wrap_xy got %0d,%0d want 0,0", scan.x, scan.y);
                end
            end
        end
        checks++;
        if (pulses !== 2) begin
            errors++; $display("FAIL frame_pulses got %0d want 2", pulses);
        end else begin
            checks++;
            if (p1 !== FRAME) begin
                errors++; $display("FAIL frame_first got %0d want %0d", p1, FRAME);
            end
            checks++;
            if (p2 - p1 !== FRAME) begin
                errors++; $display("FAIL frame_interval got %0d want %0d", p2 - p1, FRAME);
            end
            checks++;
            if (vs_low !== VS * HT * DIV) begin
                errors++; $display("FAIL vs_width got %0d want %0d", vs_low, VS * HT * DIV);
            end
        end
    endtask

    task automatic test_alignment(input logic te);
        int          ticks, guard;
        logic [15:0] px;
        logic [13:0] exp;
        test_en = te;
        sb.delete();
        @(negedge clk);
        px = scan.x; ticks = 0; guard = 0;
        while (ticks < HT * VT + 12 && guard < (HT * VT + 12) * DIV * 2) begin
            @(negedge clk); guard++;
            if (scan.x !== px) begin
                ticks++;
                if (sb.size() > 0) begin
                    exp = sb.pop_front();
                    checks++;
                    if ({vga_r, vga_g, vga_b, vga_hs, vga_vs} !== exp) begin
                        errors++;
                        $display("FAIL align te=%b at x=%0d y=%0d got rgb=%h hs=%b vs=%b want rgb=%h hs=%b vs=%b",
                                 te, scan.x, scan.y, {vga_r, vga_g, vga_b}, vga_hs, vga_vs, exp[13:2], exp[1], exp[0]);
                    end
                end
                sb.push_back(exp_pins(int'(scan.x), int'(scan.y), te));
                px = scan.x;
            end
        end
        checks++;
        if (ticks !== HT * VT + 12) begin
            errors++; $display("FAIL align_ticks got %0d want %0d", ticks, HT * VT + 12);
        end
        test_en = 1'b0;
    endtask

    task automatic test_reset_midframe;
        bit found = 0;
        int pulses = 0;
        for (int i = 0; i < 2 * FRAME && !found; i++) begin
            @(negedge clk);
            if (scan.x === 16'd10 && scan.y === 16'd5) found = 1;
        end
        checks++;
        if (!found) begin
            errors++; $display("FAIL midreset_reach got none want x=10 y=5");
        end
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({scan.x, scan.y, vga_r, vga_g, vga_b, vga_hs, vga_vs, vblank, frame_count} !== {32'h0, 12'h000, 2'b11, 1'b0, 16'h0}) begin
            errors++;
            $display("FAIL midreset_state got x=%0d y=%0d rgb=%h hs=%b vs=%b vb=%b fc=%0d want 0 0 000 1 1 0 0",
                     scan.x, scan.y, {vga_r, vga_g, vga_b}, vga_hs, vga_vs, vblank, frame_count);
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < FRAME - 50; i++) begin
            @(posedge clk); #1;
            if (frame_start === 1'b1) pulses++;
        end
        checks++;
        if (pulses !== 0) begin
            errors++; $display("FAIL midreset_no_pulse got %0d pulses want 0", pulses);
        end
    endtask

    initial begin
        test_reset();
        test_hsync();
        test_frame();
        test_alignment(1'b0);
        test_alignment(1'b1);
        test_reset_midframe();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
